// File: rtl/athena_trackball_emu.sv
// rtl/athena_trackball_emu.sv - paced, accelerating d-pad to trackball delta emulation
module athena_trackball_emu #(
   parameter int unsigned TICK_DIV  = 524288,
   parameter logic [7:0]  MIN_SPEED = 8'h10,
   parameter logic [7:0]  MAX_SPEED = 8'h50,
   parameter logic [7:0]  ACCEL     = 8'h08
) (
   input  logic       clk_74a,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       dpad_left,
   input  logic       dpad_right,
   input  logic       dpad_up,
   input  logic       dpad_down,
   output logic       tick,
   output logic [7:0] trackball_x,
   output logic [7:0] trackball_y
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST_COUNT = CW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_NEG  = 2'd1,
      DIR_POS  = 2'd2
   } dir_t;

   logic [CW-1:0] prescaler;
   logic          strobe;
   logic [7:0]    speed_x, speed_y;
   dir_t          last_dir_x, last_dir_y;

   dir_t          dir_x, dir_y;
   logic [7:0]    speed_x_nxt, speed_y_nxt;
   logic [7:0]    delta_x_nxt, delta_y_nxt;

   function automatic dir_t decode(input logic neg, input logic pos);
      case ({neg, pos})
         2'b10:   return DIR_NEG;
         2'b01:   return DIR_POS;
         default: return DIR_NONE;
      endcase
   endfunction

   // Sum is widened to 9 bits so the saturation compare cannot be fooled by a wrap.
   function automatic logic [7:0] next_speed(input dir_t dir, input dir_t last, input logic [7:0] speed);
      logic [8:0] sum;
      sum = {1'b0, speed} + {1'b0, ACCEL};
      if (dir == DIR_NONE)
         return 8'h00;
      else if (dir != last)
         return MIN_SPEED;
      else if (sum > {1'b0, MAX_SPEED})
         return MAX_SPEED;
      else
         return sum[7:0];
   endfunction

   function automatic logic [7:0] to_delta(input dir_t dir, input logic [7:0] speed);
      return (dir == DIR_POS) ? speed : 8'h00 - speed;
   endfunction

   assign strobe = (prescaler == LAST_COUNT);

   always_comb begin
      dir_x       = DIR_NONE;
      dir_y       = DIR_NONE;
      speed_x_nxt = 8'h00;
      speed_y_nxt = 8'h00;
      delta_x_nxt = 8'h00;
      delta_y_nxt = 8'h00;

      dir_x       = decode(dpad_left, dpad_right);
      dir_y       = decode(dpad_up, dpad_down);
      speed_x_nxt = next_speed(dir_x, last_dir_x, speed_x);
      speed_y_nxt = next_speed(dir_y, last_dir_y, speed_y);
      delta_x_nxt = to_delta(dir_x, speed_x_nxt);
      delta_y_nxt = to_delta(dir_y, speed_y_nxt);
   end

   // A disabled emulator looks exactly like one fresh out of reset.
   always_ff @(posedge clk_74a) begin
      if (!reset_n || !enable) begin
         prescaler   <= '0;
         tick        <= 1'b0;
         trackball_x <= 8'h00;
         trackball_y <= 8'h00;
         speed_x     <= 8'h00;
         speed_y     <= 8'h00;
         last_dir_x  <= DIR_NONE;
         last_dir_y  <= DIR_NONE;
      end else begin
         tick <= strobe;
         if (strobe) begin
            prescaler   <= '0;
            trackball_x <= delta_x_nxt;
            trackball_y <= delta_y_nxt;
            speed_x     <= speed_x_nxt;
            speed_y     <= speed_y_nxt;
            last_dir_x  <= dir_x;
            last_dir_y  <= dir_y;
         end else begin
            prescaler <= prescaler + CW'(1);
         end
      end
   end

endmodule
